// File: rtl/overlay_mixer_if.sv
// overlay_mixer_if
//   Groups the pixel/sync bus between the emblem generator stage and the
//   overlay mixer.
//   master : upstream driver (sync, pixels, dither coordinates, enable),
//            receives the registered video outputs.
//   slave  : the mixer (consumes the inputs, drives the registered outputs).
//   Signals:
//     hsync_in, vsync_in, active_in : sync and visible-area flags (same cycle as pixels)
//     dith_x, dith_y                : x[0], y[0] of the current pixel
//     bg_rgb, ov_rgb                : background / overlay pixel {R1R0,G1G0,B1B0}
//     ov_enable                     : overlay requested visible (level)
//     hsync, vsync, rgb             : 1-cycle delayed syncs and composited pixel
//     fade_level                    : current blend level 0..4
interface overlay_mixer_if;
    logic       hsync_in;
    logic       vsync_in;
    logic       active_in;
    logic       dith_x;
    logic       dith_y;
    logic [5:0] bg_rgb;
    logic [5:0] ov_rgb;
    logic       ov_enable;
    logic       hsync;
    logic       vsync;
    logic [5:0] rgb;
    logic [2:0] fade_level;

    modport master (
        output hsync_in, vsync_in, active_in, dith_x, dith_y,
               bg_rgb, ov_rgb, ov_enable,
        input  hsync, vsync, rgb, fade_level
    );

    modport slave (
        input  hsync_in, vsync_in, active_in, dith_x, dith_y,
               bg_rgb, ov_rgb, ov_enable,
        output hsync, vsync, rgb, fade_level
    );
endinterface

// File: rtl/overlay_mixer.sv
// overlay_mixer
//   Keys out KEY_COLOR from the overlay pixel, composites the overlay over
//   the background and fades it in/out one blend level every FADE_FRAMES
//   frames. rgb/hsync/vsync are registered so they leave aligned.
//   Ports:
//     clk   : pixel clock
//     rst_n : synchronous active-low reset
//     vid   : overlay_mixer_if.slave (inputs *_in/pixels/enable, outputs
//             hsync, vsync, rgb, fade_level)
//   Configuration macro OVERLAY_MIXER_DITHER_EN:
//     defined     -> ordered 2x2 dither between overlay and background
//     not defined -> overlay shown when fade_level >= 2, dither inputs ignored
module overlay_mixer #(
    parameter logic [5:0]  KEY_COLOR   = 6'b100001,
    parameter int unsigned FADE_FRAMES = 4,
    parameter logic        VSYNC_POL   = 1'b0
) (
    input  logic           clk,
    input  logic           rst_n,
    overlay_mixer_if.slave vid
);

    typedef enum logic [1:0] {HIDDEN, FADE_IN, SHOWN, FADE_OUT} state_t;

    localparam logic [3:0] CNT_LAST = 4'(FADE_FRAMES - 1);

    state_t     state_q, state_d;
    logic [2:0] level_q, level_d;
    logic [3:0] cnt_q,   cnt_d;
    logic       vsync_q, hsync_q;
    logic [5:0] rgb_q,   rgb_d;
    logic       frame_tick;
    logic       show;

    // Start of vsync: input at asserted level, registered copy not yet.
    assign frame_tick = (vid.vsync_in == VSYNC_POL) && (vsync_q != VSYNC_POL);

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= HIDDEN;
            level_q <= '0;
            cnt_q   <= '0;
            vsync_q <= ~VSYNC_POL;
            hsync_q <= 1'b1;
            rgb_q   <= '0;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            vsync_q <= vid.vsync_in;
            hsync_q <= vid.hsync_in;
            rgb_q   <= rgb_d;
        end
    end

    // Next-state logic. The tick that leaves HIDDEN/SHOWN already counts as
    // the first frame of the fade; a direction reversal mid-fade only clears
    // the frame counter and keeps the level.
    always_comb begin
        state_d = state_q;
        level_d = level_q;
        cnt_d   = cnt_q;
        if (frame_tick) begin
            if (vid.ov_enable) begin
                case (state_q)
                    SHOWN: ;
                    FADE_OUT: begin
                        state_d = FADE_IN;
                        cnt_d   = '0;
                    end
                    default: begin
                        if (cnt_q == CNT_LAST) begin
                            cnt_d   = '0;
                            level_d = level_q + 3'd1;
                            state_d = (level_q == 3'd3) ? SHOWN : FADE_IN;
                        end else begin
                            cnt_d   = cnt_q + 4'd1;
                            state_d = FADE_IN;
                        end
                    end
                endcase
            end else begin
                case (state_q)
                    HIDDEN: ;
                    FADE_IN: begin
                        state_d = FADE_OUT;
                        cnt_d   = '0;
                    end
                    default: begin
                        if (cnt_q == CNT_LAST) begin
                            cnt_d   = '0;
                            level_d = level_q - 3'd1;
                            state_d = (level_q == 3'd1) ? HIDDEN : FADE_OUT;
                        end else begin
                            cnt_d   = cnt_q + 4'd1;
                            state_d = FADE_OUT;
                        end
                    end
                endcase
            end
        end
    end

    // Output logic: pixel select
`ifdef OVERLAY_MIXER_DITHER_EN
    logic [1:0] bayer;
    assign bayer = {vid.dith_x ^ vid.dith_y, vid.dith_y};
    assign show  = ({1'b0, bayer} < level_q);
`else
    logic unused_dith;
    assign unused_dith = vid.dith_x ^ vid.dith_y;
    assign show        = (level_q >= 3'd2);
`endif

    always_comb begin
        rgb_d = vid.bg_rgb;
        if (!vid.active_in)
            rgb_d = '0;
        else if (vid.ov_rgb != KEY_COLOR && show)
            rgb_d = vid.ov_rgb;
    end

    assign vid.hsync      = hsync_q;
    assign vid.vsync      = vsync_q;
    assign vid.rgb        = rgb_q;
    assign vid.fade_level = level_q;

endmodule

// File: tb/tb_overlay_mixer.sv
module tb_overlay_mixer;
    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_errors = 0;

    overlay_mixer_if vid ();

    overlay_mixer #(
        .KEY_COLOR   (6'b100001),
        .FADE_FRAMES (4),
        .VSYNC_POL   (1'b0)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .vid   (vid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One frame boundary: vsync asserted for one cycle then released.
    task automatic tick();
        vid.vsync_in = 1'b0;
        step();
        vid.vsync_in = 1'b1;
        step();
    endtask

    task automatic pix(input string tag, input logic x, input logic y,
                       input logic [5:0] bg, input logic [5:0] ov, input logic [5:0] exp);
        vid.active_in = 1'b1;
        vid.dith_x    = x;
        vid.dith_y    = y;
        vid.bg_rgb    = bg;
        vid.ov_rgb    = ov;
        step();
        check(tag, {2'b00, vid.rgb}, {2'b00, exp});
    endtask

    initial begin
        int low_cnt;
        logic [5:0] dith_bg10, dith_bg01;
        rst_n         = 1'b0;
        vid.hsync_in  = 1'b1;
        vid.vsync_in  = 1'b1;
        vid.active_in = 1'b1;
        vid.dith_x    = 1'b0;
        vid.dith_y    = 1'b0;
        vid.bg_rgb    = 6'h0C;
        vid.ov_rgb    = 6'h30;
        vid.ov_enable = 1'b1;

        // Reset held 3 cycles
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst_rgb",   {2'b00, vid.rgb}, 8'h00);
            check("rst_level", {5'b0, vid.fade_level}, 8'd0);
            check("rst_vsync", {7'b0, vid.vsync}, 8'd1);
        end
        rst_n = 1'b1;
        step();
        check("post_rst_level", {5'b0, vid.fade_level}, 8'd0);

        // Fade in: level steps on ticks 4, 8, 12, 16
        for (int i = 1; i <= 16; i++) begin
            tick();
            check($sformatf("fadein_t%0d", i), {5'b0, vid.fade_level}, 8'(i / 4));
        end

        // Level 4: overlay on every pixel, key colour shows background
        pix("shown_00", 1'b0, 1'b0, 6'h03, 6'h30, 6'h30);
        pix("shown_10", 1'b1, 1'b0, 6'h03, 6'h30, 6'h30);
        pix("shown_01", 1'b0, 1'b1, 6'h03, 6'h30, 6'h30);
        pix("shown_11", 1'b1, 1'b1, 6'h03, 6'h30, 6'h30);
        pix("key",      1'b0, 1'b0, 6'h0C, 6'h21, 6'h0C);

        // Inactive area blanks; hsync delayed exactly one cycle
        vid.active_in = 1'b0;
        vid.ov_rgb    = 6'h3F;
        low_cnt       = 0;
        for (int c = 0; c < 100; c++) begin
            vid.hsync_in = (c >= 2 && c < 98) ? 1'b0 : 1'b1;
            step();
            if (vid.hsync == 1'b0) low_cnt++;
            if (c == 1)  check("hs_before", {7'b0, vid.hsync}, 8'd1);
            if (c == 2)  check("hs_lead",   {7'b0, vid.hsync}, 8'd0);
            if (c == 2)  check("blank_rgb", {2'b00, vid.rgb}, 8'h00);
            if (c == 97) check("hs_last",   {7'b0, vid.hsync}, 8'd0);
            if (c == 98) check("hs_trail",  {7'b0, vid.hsync}, 8'd1);
        end
        check("hs_width", 8'(low_cnt), 8'd96);

        // Full fade out to HIDDEN
        vid.ov_enable = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            tick();
            check($sformatf("fadeout_t%0d", i), {5'b0, vid.fade_level}, 8'(4 - i / 4));
        end

        // Fade in to level 2, check dither pattern
        vid.ov_enable = 1'b1;
        for (int i = 1; i <= 8; i++) tick();
        check("lvl2", {5'b0, vid.fade_level}, 8'd2);
`ifdef OVERLAY_MIXER_DITHER_EN
        dith_bg10 = 6'h03;
        dith_bg01 = 6'h03;
`else
        dith_bg10 = 6'h30;
        dith_bg01 = 6'h30;
`endif
        pix("l2_00", 1'b0, 1'b0, 6'h03, 6'h30, 6'h30);
        pix("l2_11", 1'b1, 1'b1, 6'h03, 6'h30, 6'h30);
        pix("l2_10", 1'b1, 1'b0, 6'h03, 6'h30, dith_bg10);
        pix("l2_01", 1'b0, 1'b1, 6'h03, 6'h30, dith_bg01);

        // Reach level 3, then reverse mid-fade
        for (int i = 9; i <= 12; i++) tick();
        check("lvl3", {5'b0, vid.fade_level}, 8'd3);
        vid.ov_enable = 1'b0;
        tick();
        check("rev_keep", {5'b0, vid.fade_level}, 8'd3);
        for (int i = 1; i <= 3; i++) tick();
        check("rev_hold3", {5'b0, vid.fade_level}, 8'd3);
        tick();
        check("rev_lvl2", {5'b0, vid.fade_level}, 8'd2);
        for (int i = 1; i <= 4; i++) tick();
        check("rev_lvl1", {5'b0, vid.fade_level}, 8'd1);
        pix("l1_bg", 1'b0, 1'b0, 6'h03, 6'h30,
`ifdef OVERLAY_MIXER_DITHER_EN
            6'h30
`else
            6'h03
`endif
        );
        for (int i = 1; i <= 4; i++) tick();
        check("rev_lvl0", {5'b0, vid.fade_level}, 8'd0);
        for (int i = 1; i <= 6; i++) tick();
        check("hidden_stay", {5'b0, vid.fade_level}, 8'd0);
        pix("hidden_bg", 1'b1, 1'b1, 6'h03, 6'h30, 6'h03);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
